// File: rtl/uart_bytes_rx_pkg.sv
// Purpose: shared types for the multi-byte UART receiver.
//   BYTE_W      - width of one UART data byte
//   rx_state_e  - single-byte receive FSM states
package uart_bytes_rx_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

endpackage

// File: rtl/uart_rx.sv
// Purpose: single-byte 8N1 UART receiver with input synchroniser.
// Ports:
//   sys_clk, sys_rst_n  - clock, asynchronous active-low reset
//   uart_rxd            - raw serial input (asynchronous, idle high)
//   uart_rx_data        - last received byte, LSB received first
//   uart_rx_done        - 1-cycle pulse one cycle after a good stop-bit sample
//   uart_rx_err         - 1-cycle pulse one cycle after a low stop-bit sample
//   uart_rx_idle_c      - combinational: FSM is waiting for a start edge
module uart_rx
    import uart_bytes_rx_pkg::*;
#(
    parameter int unsigned BIT_CNT = 5208
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              uart_rxd,
    output logic [BYTE_W-1:0] uart_rx_data,
    output logic              uart_rx_done,
    output logic              uart_rx_err,
    output logic              uart_rx_idle_c
);

    localparam int unsigned HALF_CNT = BIT_CNT / 2;
    localparam int unsigned CNT_W    = (BIT_CNT > 1) ? $clog2(BIT_CNT) : 1;

    // [0]: first sync FF, [1]: synchronised rxd, [2]: previous synchronised rxd
    logic [2:0]        sync_q;
    rx_state_e         state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [2:0]        bit_q;
    logic [BYTE_W-1:0] shift_q;
    logic              done_q;
    logic              err_q;

    logic rxd_s;
    logic fall_edge;

    assign rxd_s     = sync_q[1];
    assign fall_edge = sync_q[2] & ~sync_q[1];

    // Synchroniser and byte FSM; mid-bit sampling is timed from the start edge
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync_q  <= 3'b111;
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            sync_q <= {sync_q[1:0], uart_rxd};
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                RX_IDLE: begin
                    if (fall_edge) begin
                        state_q <= RX_START;
                        cnt_q   <= '0;
                    end
                end
                RX_START: begin
                    if (cnt_q == CNT_W'(HALF_CNT - 1)) begin
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        // Line back high at mid-start: treat as a glitch
                        state_q <= rxd_s ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                RX_DATA: begin
                    if (cnt_q == CNT_W'(BIT_CNT - 1)) begin
                        cnt_q   <= '0;
                        shift_q <= {rxd_s, shift_q[BYTE_W-1:1]};
                        bit_q   <= bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            state_q <= RX_STOP;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                RX_STOP: begin
                    if (cnt_q == CNT_W'(BIT_CNT - 1)) begin
                        // Leave at mid-stop so a back-to-back start edge is seen
                        cnt_q   <= '0;
                        state_q <= RX_IDLE;
                        done_q  <= rxd_s;
                        err_q   <= ~rxd_s;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= RX_IDLE;
            endcase
        end
    end

    assign uart_rx_data   = shift_q;
    assign uart_rx_done   = done_q;
    assign uart_rx_err    = err_q;
    assign uart_rx_idle_c = (state_q == RX_IDLE);

endmodule

// File: rtl/uart_bytes_rx.sv
// Purpose: multi-byte UART receiver; assembles BYTES 8N1 frames (low byte
// first) into one word, with frame-error and inter-byte timeout handling.
// Ports:
//   sys_clk, sys_rst_n - clock, asynchronous active-low reset
//   uart_rxd           - raw serial input
//   uart_bytes_data    - last complete packet, first received byte in [7:0]
//   uart_bytes_done    - 1-cycle pulse: new packet on uart_bytes_data
//   uart_frame_err     - 1-cycle pulse: bad stop bit, partial packet dropped
//   uart_timeout       - 1-cycle pulse: inter-byte gap too long, partial dropped
module uart_bytes_rx
    import uart_bytes_rx_pkg::*;
#(
    parameter int unsigned BYTES        = 4,
    parameter int unsigned BPS          = 9_600,
    parameter int unsigned CLK_FRE      = 50_000_000,
    parameter int unsigned TIMEOUT_BITS = 16
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic                 uart_rxd,
    output logic [BYTES*8-1:0]   uart_bytes_data,
    output logic                 uart_bytes_done,
    output logic                 uart_frame_err,
    output logic                 uart_timeout
);

    localparam int unsigned WORD_W      = BYTES * BYTE_W;
    localparam int unsigned BIT_CNT     = CLK_FRE / BPS;
    localparam int unsigned TIMEOUT_CNT = TIMEOUT_BITS * BIT_CNT;
    localparam int unsigned BCNT_W      = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int unsigned GAP_W       = $clog2(TIMEOUT_CNT + 1);

    logic [BYTE_W-1:0] rx_data;
    logic              rx_done;
    logic              rx_err;
    logic              rx_idle;

    uart_rx #(
        .BIT_CNT (BIT_CNT)
    ) u_uart_rx (
        .sys_clk        (sys_clk),
        .sys_rst_n      (sys_rst_n),
        .uart_rxd       (uart_rxd),
        .uart_rx_data   (rx_data),
        .uart_rx_done   (rx_done),
        .uart_rx_err    (rx_err),
        .uart_rx_idle_c (rx_idle)
    );

    logic [WORD_W-1:0] asm_q,      asm_d;
    logic [WORD_W-1:0] data_q,     data_d;
    logic [BCNT_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [GAP_W-1:0]  gap_q,      gap_d;
    logic              done_q,     done_d;
    logic              ferr_q,     ferr_d;
    logic              tmo_q,      tmo_d;

    logic [WORD_W-1:0] asm_next;

    // New byte enters the top lane; older bytes move down by one lane
    assign asm_next = WORD_W'({rx_data, asm_q} >> BYTE_W);

    // Packet assembly, byte counting and inter-byte gap timer
    always_comb begin
        asm_d      = asm_q;
        data_d     = data_q;
        byte_cnt_d = byte_cnt_q;
        gap_d      = '0;
        done_d     = 1'b0;
        ferr_d     = 1'b0;
        tmo_d      = 1'b0;
        if (rx_err) begin
            ferr_d     = 1'b1;
            byte_cnt_d = '0;
        end else if (rx_done) begin
            asm_d = asm_next;
            if (byte_cnt_q == BCNT_W'(BYTES - 1)) begin
                data_d     = asm_next;
                done_d     = 1'b1;
                byte_cnt_d = '0;
            end else begin
                byte_cnt_d = byte_cnt_q + BCNT_W'(1);
            end
        end else if ((byte_cnt_q != '0) && rx_idle) begin
            // Gap timer only runs mid-packet while the line is idle
            if (gap_q == GAP_W'(TIMEOUT_CNT - 1)) begin
                tmo_d      = 1'b1;
                byte_cnt_d = '0;
            end else begin
                gap_d = gap_q + GAP_W'(1);
            end
        end
    end

    // State and output registers
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            asm_q      <= '0;
            data_q     <= '0;
            byte_cnt_q <= '0;
            gap_q      <= '0;
            done_q     <= 1'b0;
            ferr_q     <= 1'b0;
            tmo_q      <= 1'b0;
        end else begin
            asm_q      <= asm_d;
            data_q     <= data_d;
            byte_cnt_q <= byte_cnt_d;
            gap_q      <= gap_d;
            done_q     <= done_d;
            ferr_q     <= ferr_d;
            tmo_q      <= tmo_d;
        end
    end

    assign uart_bytes_data = data_q;
    assign uart_bytes_done = done_q;
    assign uart_frame_err  = ferr_q;
    assign uart_timeout    = tmo_q;

endmodule

// File: tb/tb_uart_bytes_rx.sv
// Testbench for uart_bytes_rx: serialises packets from a byte-level model,
// queues the expected events and checks them in an independent monitor.
module tb_uart_bytes_rx;

    localparam int unsigned BYTES        = 4;
    localparam int unsigned BPS          = 100_000;
    localparam int unsigned CLK_FRE      = 1_000_000;
    localparam int unsigned TIMEOUT_BITS = 16;
    localparam int unsigned BIT          = CLK_FRE / BPS;
    localparam int unsigned W            = BYTES * 8;

    typedef enum int {EV_DONE = 0, EV_FERR = 1, EV_TMO = 2} ev_kind_e;
    typedef struct {
        ev_kind_e     kind;
        logic [W-1:0] word;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         rxd = 1'b1;
    logic [W-1:0] data;
    logic         done;
    logic         ferr;
    logic         tmo;

    int unsigned  cyc = 0;
    int unsigned  tmo_cyc = 0;
    int unsigned  done_cnt = 0;
    logic [W-1:0] model_word = '0;

    uart_bytes_rx #(
        .BYTES        (BYTES),
        .BPS          (BPS),
        .CLK_FRE      (CLK_FRE),
        .TIMEOUT_BITS (TIMEOUT_BITS)
    ) dut (
        .sys_clk         (clk),
        .sys_rst_n       (rst_n),
        .uart_rxd        (rxd),
        .uart_bytes_data (data),
        .uart_bytes_done (done),
        .uart_frame_err  (ferr),
        .uart_timeout    (tmo)
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d events pending", exp_q.size());
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops an expected event for every pulse the DUT presents
    always @(negedge clk) begin : monitor
        ev_t      ev;
        ev_kind_e act;
        int       n;
        if (!rst_n) begin
            model_word = '0;
        end else begin
            n = int'(done) + int'(ferr) + int'(tmo);
            if (n > 1) begin
                checks++;
                errors++;
                $display("FAIL exclusive_flags: done=%b ferr=%b tmo=%b", done, ferr, tmo);
            end
            if (n > 0) begin
                act = done ? EV_DONE : (ferr ? EV_FERR : EV_TMO);
                if (tmo) tmo_cyc = cyc;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event: got kind %0d expected none", int'(act));
                end else begin
                    ev = exp_q.pop_front();
                    check("event_kind", W'(act), W'(ev.kind));
                    if (done) begin
                        check("bytes_data", data, ev.word);
                        model_word = ev.word;
                        done_cnt++;
                    end else begin
                        check("data_hold", data, model_word);
                    end
                end
            end
        end
    end

    task automatic expect_ev(input ev_kind_e k, input logic [W-1:0] w);
        ev_t e;
        e.kind = k;
        e.word = w;
        exp_q.push_back(e);
    endtask

    task automatic bit_time(input logic v);
        rxd = v;
        repeat (BIT) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        bit_time(1'b0);
        for (int i = 0; i < 8; i++) bit_time(b[i]);
        bit_time(stop);
        rxd = 1'b1;
    endtask

    // Low byte goes out first on the wire
    task automatic send_word(input logic [W-1:0] w);
        for (int i = 0; i < BYTES; i++) send_byte(w[8*i +: 8], 1'b1);
    endtask

    task automatic idle_bits(input int unsigned bits);
        rxd = 1'b1;
        repeat (bits * BIT) @(negedge clk);
    endtask

    task automatic drain(input string name);
        int unsigned n;
        n = 0;
        while (exp_q.size() != 0 && n < 50 * BIT) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d events pending, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        logic [W-1:0] w;
        int unsigned  t_end;
        int unsigned  diff;
        int unsigned  d0;
        logic [7:0]   b2;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_data", data, '0);
        check("reset_done", W'(done), '0);
        check("reset_ferr", W'(ferr), '0);
        check("reset_tmo",  W'(tmo),  '0);
        rst_n = 1'b1;
        idle_bits(2);

        // Back-to-back packet
        expect_ev(EV_DONE, 32'hABCD1234);
        send_word(32'hABCD1234);
        idle_bits(2);
        drain("pkt_basic");

        // Short glitch on an idle line, then a normal packet
        rxd = 1'b0;
        repeat (2) @(negedge clk);
        idle_bits(3);
        check("glitch_no_done", W'(done_cnt), W'(1));
        expect_ev(EV_DONE, 32'h0F1E2D3C);
        send_word(32'h0F1E2D3C);
        idle_bits(2);
        drain("pkt_after_glitch");

        // Second byte with a low stop bit
        send_byte(8'h5A, 1'b1);
        expect_ev(EV_FERR, '0);
        send_byte(8'h77, 1'b0);
        idle_bits(2);
        drain("frame_err");
        expect_ev(EV_DONE, 32'h89ABCDEF);
        send_word(32'h89ABCDEF);
        idle_bits(2);
        drain("pkt_after_ferr");

        // Two bytes then a long gap
        send_byte(8'hC3, 1'b1);
        expect_ev(EV_TMO, '0);
        send_byte(8'h3C, 1'b1);
        t_end = cyc;
        idle_bits(20);
        drain("timeout");
        diff = tmo_cyc - t_end;
        checks++;
        if (diff < (TIMEOUT_BITS - 1) * BIT || diff > (TIMEOUT_BITS + 1) * BIT) begin
            errors++;
            $display("FAIL timeout_delay: got %0d cycles expected %0d..%0d",
                     diff, (TIMEOUT_BITS - 1) * BIT, (TIMEOUT_BITS + 1) * BIT);
        end
        expect_ev(EV_DONE, 32'h44332211);
        send_word(32'h44332211);
        idle_bits(2);
        drain("pkt_after_tmo");

        // Reset during bit 5 of byte 3
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        b2 = 8'hA5;
        bit_time(1'b0);
        for (int i = 0; i < 5; i++) bit_time(b2[i]);
        rxd = b2[5];
        repeat (BIT / 2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_data", data, '0);
        check("midrst_done", W'(done), '0);
        check("midrst_ferr", W'(ferr), '0);
        check("midrst_tmo",  W'(tmo),  '0);
        repeat (3) @(negedge clk);
        rxd = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle_bits(2);
        expect_ev(EV_DONE, 32'hDEADBEEF);
        send_word(32'hDEADBEEF);
        idle_bits(2);
        drain("pkt_after_reset");

        // Random packets with random inter-packet idle
        d0 = done_cnt;
        for (int k = 0; k < 100; k++) begin
            w = W'($urandom());
            expect_ev(EV_DONE, w);
            send_word(w);
            idle_bits($urandom_range(0, 2));
        end
        idle_bits(2);
        drain("random_pkts");
        check("random_done_count", W'(done_cnt - d0), W'(100));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
